// File: rtl/store_buffer_pkg.sv
// Shared types for the write-through store buffer: entry layout, access size and drain FSM state.
package store_buffer_pkg;

    localparam int SB_DEPTH      = 4;
    localparam int SB_DATA_WIDTH = 32;

    typedef logic [SB_DATA_WIDTH-1:0] data_bus_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } byte_format_t;

    typedef struct packed {
        data_bus_t    addr;
        data_bus_t    data;
        byte_format_t size;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    function automatic logic is_word(input byte_format_t size);
        return size == SZ_WORD;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular entry queue for the store buffer: head/tail pointers, occupancy and push/pop.
// With STORE_BUF_FWD_EN defined, the raw entry array and head pointer are exported for the load search.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  sb_entry_t        push_entry_i,
    input  logic             pop_i,
    output sb_entry_t        head_entry_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
`ifdef STORE_BUF_FWD_EN
    ,
    output sb_entry_t        entries_o [DEPTH],
    output logic [PTR_W-1:0] head_ptr_o
`endif
);

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign count_o      = count_q;
    assign head_entry_o = mem_q[head_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && (count_q != '0);
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_entry_i;
    end

`ifdef STORE_BUF_FWD_EN
    assign entries_o  = mem_q;
    assign head_ptr_o = head_q;
`endif

endmodule

// File: rtl/store_buffer.sv
// Write-through store buffer: queues CPU stores and drains them to memory over req/ack.
// Define STORE_BUF_FWD_EN to add youngest-first word forwarding to loads (ld_* ports).
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH      = SB_DEPTH,
    parameter  int DATA_WIDTH = SB_DATA_WIDTH,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [DATA_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    input  logic [1:0]            st_size_i,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [1:0]            mem_size_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
`ifdef STORE_BUF_FWD_EN
    ,
    input  logic [DATA_WIDTH-1:0] ld_addr_i,
    output logic                  ld_hit_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic                  ld_conflict_o
`endif
);

    sb_state_t        state_q, state_d;
    sb_entry_t        push_entry;
    sb_entry_t        head_entry;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push_ok;
    logic             pop;

`ifdef STORE_BUF_FWD_EN
    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
`endif

    assign push_entry = '{addr: st_addr_i, data: st_data_i, size: byte_format_t'(st_size_i)};
    assign st_ready_o = !full;
    assign push_ok    = st_valid_i && st_ready_o;
    assign pop        = (state_q == SB_REQ) && mem_ack_i;
    assign count_o    = count;
    assign empty_o    = (count == '0) && (state_q == SB_IDLE);

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_ok),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .count_o      (count),
        .full_o       (full)
`ifdef STORE_BUF_FWD_EN
        ,
        .entries_o    (entries),
        .head_ptr_o   (head_ptr)
`endif
    );

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_size_o = '0;
        case (state_q)
            SB_IDLE: begin
                if (count != '0) state_d = SB_REQ;
            end
            SB_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = head_entry.addr;
                mem_data_o = head_entry.data;
                mem_size_o = head_entry.size;
                // Leaving REQ only when the acked entry was the last and nothing new arrives.
                if (mem_ack_i && (count == CNT_W'(1)) && !push_ok) state_d = SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= SB_IDLE;
        else     state_q <= state_d;
    end

`ifdef STORE_BUF_FWD_EN
    // Walk oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_hit_o      = 1'b0;
        ld_conflict_o = 1'b0;
        ld_data_o     = '0;
        idx           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (((entries[idx].addr ^ ld_addr_i) >> 2) == '0)) begin
                if (is_word(entries[idx].size)) begin
                    ld_hit_o      = 1'b1;
                    ld_conflict_o = 1'b0;
                    ld_data_o     = entries[idx].data;
                end else begin
                    ld_hit_o      = 1'b0;
                    ld_conflict_o = 1'b1;
                    ld_data_o     = '0;
                end
            end
        end
    end
`endif

endmodule
